sync_fifo_flags: RTL and testbench

//  Parametrised synchronous sample FIFO for the audio effects path (ADC->effect, effect->DAC buffering).

---
 rtl/sync_fifo_flags.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: audio sample FIFO with fill-level flags and sticky errors; SYNC_FIFO_FWFT_EN selects first-word-fall-through.
// Latency: standard read data 1 cycle after rd_en; FWFT head word visible 2 edges after a write into an empty FIFO.
// Backpressure: writes refused while full (unless a read is accepted that cycle), reads refused while empty; refusals set sticky flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                         clk,
  input  logic                         rst_a,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         rd_en,
  input  logic                         clr_err,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [ADDR_WIDTH:0]          data_fill,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   fill_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ram_rd;

  assign data_fill    = fill_q;
  assign full         = (fill_q == FILL_MAX);
  assign empty        = (fill_q == '0);
  assign almost_full  = (fill_q >= AFULL_L);
  assign almost_empty = (fill_q <= AEMPTY_L);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = dout_q;

  // A read accepted in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_q      <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (wr_en & ~wr_acc) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (rd_en & ~rd_acc) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  typedef enum logic {IDLE = 1'b0, LOADED = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_WIDTH:0] ram_cnt_q;
  logic                ram_has;

  // ram_cnt_q counts words still in RAM; the word held in dout_q is excluded.
  assign ram_has    = (ram_cnt_q != '0);
  assign rd_acc     = rd_en & (state_q == LOADED);
  assign data_valid = (state_q == LOADED);

  always_comb begin
    state_d = state_q;
    ram_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_has) begin
          state_d = LOADED;
          ram_rd  = 1'b1;
        end
      end
      LOADED: begin
        if (rd_acc) begin
          if (ram_has) begin
            ram_rd = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q   <= IDLE;
      ram_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case ({wr_acc, ram_rd})
        2'b10:   ram_cnt_q <= ram_cnt_q + 1'b1;
        2'b01:   ram_cnt_q <= ram_cnt_q - 1'b1;
        default: ram_cnt_q <= ram_cnt_q;
      endcase
    end
  end
`else
  logic valid_q;

  assign rd_acc     = rd_en & ~empty;
  assign ram_rd     = rd_acc;
  assign data_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: vector table, directed corner sequences and randomized traffic against a queue model.
module tb_sync_fifo_flags;

  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 4;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        wr_en = 1'b0;
  logic [23:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [23:0] data_out;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  data_fill;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] q[$];
  logic [23:0] m_dout;
  logic        m_valid;
  logic        m_ovf;
  logic        m_udf;

  sync_fifo_flags dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_fill    (data_fill),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset(input string tag);
    rst_a = 1'b1; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0; data_in = 24'h5A5A5A;
    @(posedge clk); #1;
    rst_a = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q.delete(); m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    chk(tag, "fill", data_fill, 0);
    chk(tag, "empty", empty, 1);
    chk(tag, "full", full, 0);
    chk(tag, "aempty", almost_empty, 1);
    chk(tag, "afull", almost_full, 0);
    chk(tag, "valid", data_valid, 0);
    chk(tag, "dout", data_out, 0);
    chk(tag, "ovf", overflow, 0);
    chk(tag, "udf", underflow, 0);
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  typedef struct {
    logic        w;
    logic        r;
    logic        c;
    logic [23:0] d;
    int          fill;
    logic        valid;
    logic [23:0] dout;
    logic        ovf;
    logic        udf;
  } vec_t;

  task automatic cmp_outputs(input string tag, input int f, input logic v, input logic [23:0] d,
                             input logic o, input logic u);
    chk(tag, "fill", data_fill, f);
    chk(tag, "full", full, f == DEPTH);
    chk(tag, "empty", empty, f == 0);
    chk(tag, "afull", almost_full, f >= AFULL);
    chk(tag, "aempty", almost_empty, f <= AEMPTY);
    chk(tag, "valid", data_valid, v);
    chk(tag, "dout", data_out, d);
    chk(tag, "ovf", overflow, o);
    chk(tag, "udf", underflow, u);
  endtask

  // Reference: a queue of stored words; read takes the head before a same-cycle write appends.
  task automatic model_step(input logic w, input logic r, input logic c, input logic [23:0] d);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    m_valid = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    if (w && !wr_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !rd_ok) m_udf = 1'b1; else if (c) m_udf = 1'b0;
  endtask

  task automatic step(input string tag, input logic w, input logic r, input logic c, input logic [23:0] d);
    wr_en = w; rd_en = r; clr_err = c; data_in = d;
    @(posedge clk); #1;
    model_step(w, r, c, d);
    cmp_outputs(tag, q.size(), m_valid, m_dout, m_ovf, m_udf);
  endtask
`endif

  initial begin
`ifndef SYNC_FIFO_FWFT_EN
    vec_t tbl[12];
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 24'h000000, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 24'hFFFFFB, 1, 1'b0, 24'h000000, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0, 1'b1, 24'hFFFFFB, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 0, 1'b0, 24'hFFFFFB, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h7FFFFF, 1, 1'b0, 24'hFFFFFB, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'h800000, 2, 1'b0, 24'hFFFFFB, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1, 1'b1, 24'h7FFFFF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 0, 1'b1, 24'h800000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 0, 1'b0, 24'h800000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 24'h000000, 0, 1'b0, 24'h800000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 24'h000000, 0, 1'b0, 24'h800000, 1'b0, 1'b0};

    do_reset("reset");
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].w; rd_en = tbl[i].r; clr_err = tbl[i].c; data_in = tbl[i].d;
      @(posedge clk); #1;
      cmp_outputs($sformatf("vec%0d", i), tbl[i].fill, tbl[i].valid, tbl[i].dout, tbl[i].ovf, tbl[i].udf);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;

    do_reset("reset2");
    for (int i = 1; i <= DEPTH; i++) step("fill16", 1'b1, 1'b0, 1'b0, 24'(i));
    step("ovf_set", 1'b1, 1'b0, 1'b0, 24'h7FFFFF);
    step("ovf_clr", 1'b0, 1'b0, 1'b1, 24'h0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, 24'h0);
    step("idle", 1'b0, 1'b0, 1'b0, 24'h0);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, 1'b0, 24'(100 + i));
    for (int i = 0; i < 40; i++) step("fullrw", 1'b1, 1'b1, 1'b0, 24'(200 + i));

    for (int i = 0; i < 900; i++) begin
      int pw;
      int pr;
      logic [23:0] d;
      case ((i / 100) % 3)
        0:       begin pw = 75; pr = 30; end
        1:       begin pw = 30; pr = 75; end
        default: begin pw = 55; pr = 55; end
      endcase
      d = 24'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             $urandom_range(0, 19) == 0, d);
      end
    end
`else
    do_reset("reset");
    wr_en = 1'b1; data_in = 24'h000123;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("fwft_e1", "valid", data_valid, 0);
    chk("fwft_e1", "fill", data_fill, 1);
    chk("fwft_e1", "empty", empty, 0);
    @(posedge clk); #1;
    chk("fwft_e2", "valid", data_valid, 1);
    chk("fwft_e2", "dout", data_out, 24'h000123);
    wr_en = 1'b1; data_in = 24'h000456;
    @(posedge clk); #1;
    data_in = 24'h000789;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("fwft_w3", "fill", data_fill, 3);
    chk("fwft_w3", "dout", data_out, 24'h000123);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("fwft_pop", "dout", data_out, 24'h000456);
    chk("fwft_pop", "valid", data_valid, 1);
    chk("fwft_pop", "fill", data_fill, 2);
    wr_en = 1'b1; data_in = 24'h000AAA;
    @(posedge clk); #1;
    do_reset("fwft_midrst");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
